// File: rtl/municao_player.sv
`default_nettype none
// ============================================================================
// Module   : municao_player
// Purpose  : Player bullet controller. Launches a single bullet from the
//            player ship when fire is pressed. The bullet moves up by SPEED
//            pixels on every frame_tick and is retired when it hits an enemy
//            or leaves the top of the screen. After retirement a cooldown of
//            COOLDOWN_FRAMES frames must pass before the next launch. The
//            module also paints the bullet pixel for the VGA mux; this colour
//            output is registered, so it appears one cycle after the counters.
// Ports    : clk                  - system/pixel clock
//            reset                - asynchronous active-low reset
//            fire                 - fire button level, synchronous to clk
//            frame_tick           - one-cycle pulse per frame
//            posX/posY_player     - player sprite top-left corner
//            colisao              - OR of all enemy collision flags
//            h_counter/v_counter  - current pixel coordinates
//            posX/posY_municao_player - bullet position (OFF_POS when idle)
//            ativa                - bullet in flight
//            disparos             - launch counter, wraps 255 -> 0
//            R, G, B              - bullet pixel colour (yellow), else 0
// Config   : MUNICAO_AUTOFIRE_EN  - when defined, IDLE launches on the fire
//            level, so holding fire relaunches every time IDLE is entered.
//            When undefined, each launch needs a new rising edge of fire.
// Revision : 1.0 - initial release
// ============================================================================
module municao_player #(
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 6,
  parameter int SPEED           = 4,
  parameter int PLAYER_W        = 24,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int OFF_POS         = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       frame_tick,
  input  logic [9:0] posX_player,
  input  logic [9:0] posY_player,
  input  logic       colisao,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic [9:0] posX_municao_player,
  output logic [9:0] posY_municao_player,
  output logic       ativa,
  output logic [7:0] disparos,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  // Cooldown counter needs at least one bit even when the cooldown is zero.
  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
  localparam logic [9:0]      X_OFS   = 10'(PLAYER_W / 2 - BULLET_W / 2);
  localparam logic [9:0]      H_V     = 10'(BULLET_H);
  localparam logic [9:0]      SPEED_V = 10'(SPEED);
  localparam logic [9:0]      OFF_V   = 10'(OFF_POS);
  localparam logic [10:0]     W_EXT   = 11'(BULLET_W);
  localparam logic [10:0]     H_EXT   = 11'(BULLET_H);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VOO     = 2'd1,
    RECARGA = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [9:0]      pos_x, pos_x_n;
  logic [9:0]      pos_y, pos_y_n;
  logic            active, active_n;
  logic [7:0]      shots, shots_n;
  logic [CD_W-1:0] cooldown, cooldown_n;
  logic            fire_q;
  logic            launch;
  logic            hit;

`ifdef MUNICAO_AUTOFIRE_EN
  assign launch = fire;
`else
  assign launch = fire & ~fire_q;
`endif

  // State and data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pos_x    <= OFF_V;
      pos_y    <= OFF_V;
      active   <= 1'b0;
      shots    <= 8'd0;
      cooldown <= '0;
      fire_q   <= 1'b0;
    end else begin
      state    <= state_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      active   <= active_n;
      shots    <= shots_n;
      cooldown <= cooldown_n;
      fire_q   <= fire;
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    pos_x_n    = pos_x;
    pos_y_n    = pos_y;
    active_n   = active;
    shots_n    = shots;
    cooldown_n = cooldown;
    case (state)
      IDLE: begin
        if (launch) begin
          pos_x_n  = posX_player + X_OFS;
          // Clamp at the top edge so the subtraction can never wrap.
          pos_y_n  = (posY_player < H_V) ? 10'd0 : posY_player - H_V;
          active_n = 1'b1;
          shots_n  = shots + 8'd1;
          state_n  = VOO;
        end
      end
      VOO: begin
        // A hit takes priority over movement in the same cycle; a bullet too
        // close to the top to move another step leaves the screen instead.
        if (colisao || (frame_tick && (pos_y < SPEED_V))) begin
          pos_x_n    = OFF_V;
          pos_y_n    = OFF_V;
          active_n   = 1'b0;
          cooldown_n = CD_INIT;
          state_n    = RECARGA;
        end else if (frame_tick) begin
          pos_y_n = pos_y - SPEED_V;
        end
      end
      RECARGA: begin
        if (cooldown == '0) begin
          state_n = IDLE;
        end else if (frame_tick) begin
          cooldown_n = cooldown - CD_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bullet box test, widened by one bit so pos + size cannot overflow.
  always_comb begin
    hit = active
        && ({1'b0, h_counter} >= {1'b0, pos_x})
        && ({1'b0, h_counter} <  ({1'b0, pos_x} + W_EXT))
        && ({1'b0, v_counter} >= {1'b0, pos_y})
        && ({1'b0, v_counter} <  ({1'b0, pos_y} + H_EXT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else begin
      R <= hit ? 8'hFF : 8'h00;
      G <= hit ? 8'hFF : 8'h00;
      B <= 8'h00;
    end
  end

  assign posX_municao_player = pos_x;
  assign posY_municao_player = pos_y;
  assign ativa               = active;
  assign disparos            = shots;

endmodule
`default_nettype wire

// File: tb/tb_municao_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_municao_player
// Purpose  : Self-checking bench for municao_player. A table of per-cycle
//            vectors covers launch and flight; hand-written sequences cover
//            cooldown timing, top exit, held fire, the pixel path, counter
//            wrap and asynchronous reset. Expected results are queued when
//            stimulus is driven and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_municao_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire;
  logic       frame_tick;
  logic [9:0] posX_player;
  logic [9:0] posY_player;
  logic       colisao;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic [9:0] posX_municao_player;
  logic [9:0] posY_municao_player;
  logic       ativa;
  logic [7:0] disparos;
  logic [7:0] R, G, B;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_disp = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        a;
    logic [7:0]  d;
    logic [23:0] rgb;
    string       name;
  } exp_t;

  typedef struct {
    logic       fire;
    logic       tick;
    logic       col;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       ea;
    int         ed;
  } vec_t;

  exp_t sb[$];
  exp_t prev;
  vec_t vecs[7];

  municao_player dut (
    .clk                 (clk),
    .reset               (reset),
    .fire                (fire),
    .frame_tick          (frame_tick),
    .posX_player         (posX_player),
    .posY_player         (posY_player),
    .colisao             (colisao),
    .h_counter           (h_counter),
    .v_counter           (v_counter),
    .posX_municao_player (posX_municao_player),
    .posY_municao_player (posY_municao_player),
    .ativa               (ativa),
    .disparos            (disparos),
    .R                   (R),
    .G                   (G),
    .B                   (B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_prev_reset();
    prev.x = 10'd1023; prev.y = 10'd1023; prev.a = 1'b0; prev.d = 8'd0;
    prev.rgb = 24'h0; prev.name = "reset";
  endtask

  // Queue the expectation for the next edge, advance one clock, compare.
  task automatic cyc(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                     input logic ea, input int ed);
    exp_t e;
    exp_t got;
    int hx, vy;
    hx = int'(h_counter);
    vy = int'(v_counter);
    e.name = nm; e.x = ex; e.y = ey; e.a = ea; e.d = 8'(ed);
    // Colour reflects the bullet as it stood before this edge.
    e.rgb = (prev.a && hx >= int'(prev.x) && hx < int'(prev.x) + 2 &&
             vy >= int'(prev.y) && vy < int'(prev.y) + 6) ? 24'hFFFF00 : 24'h0;
    sb.push_back(e);
    prev = e;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, ".posX"}, 32'(posX_municao_player), 32'(got.x));
    chk({got.name, ".posY"}, 32'(posY_municao_player), 32'(got.y));
    chk({got.name, ".ativa"}, 32'(ativa), 32'(got.a));
    chk({got.name, ".disparos"}, 32'(disparos), 32'(got.d));
    chk({got.name, ".rgb"}, 32'({R, G, B}), 32'(got.rgb));
  endtask

  task automatic same(input string nm);
    cyc(nm, prev.x, prev.y, prev.a, int'(prev.d));
  endtask

  // Full cooldown with a frame_tick every cycle, then the exit cycle.
  task automatic fast_cooldown(input string nm);
    frame_tick = 1'b1;
    for (int i = 0; i < 15; i++) same(nm);
    frame_tick = 1'b0;
    same({nm, "_exit"});
  endtask

  initial begin
    reset = 1'b0; fire = 1'b0; frame_tick = 1'b0; colisao = 1'b0;
    posX_player = 10'd300; posY_player = 10'd440;
    h_counter = 10'd0; v_counter = 10'd0;

    //            fire  tick  col   px       py       ex       ey       ea   ed
    vecs[0] = '{1'b0, 1'b0, 1'b0, 10'd300, 10'd440, 10'd1023, 10'd1023, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10'd300, 10'd440, 10'd311,  10'd434,  1'b1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 10'd350, 10'd440, 10'd311,  10'd430,  1'b1, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 10'd200, 10'd100, 10'd311,  10'd426,  1'b1, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 10'd200, 10'd100, 10'd311,  10'd422,  1'b1, 1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10'd200, 10'd100, 10'd311,  10'd422,  1'b1, 1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 10'd200, 10'd100, 10'd1023, 10'd1023, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.posX", 32'(posX_municao_player), 32'd1023);
    chk("reset.posY", 32'(posY_municao_player), 32'd1023);
    chk("reset.ativa", 32'(ativa), 32'd0);
    chk("reset.disparos", 32'(disparos), 32'd0);
    chk("reset.rgb", 32'({R, G, B}), 32'd0);
    reset = 1'b1;
    set_prev_reset();

    // Launch, flight and hit-beats-tick from the table.
    for (int i = 0; i < 7; i++) begin
      fire = vecs[i].fire; frame_tick = vecs[i].tick; colisao = vecs[i].col;
      posX_player = vecs[i].px; posY_player = vecs[i].py;
      cyc($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ea, vecs[i].ed);
    end
    frame_tick = 1'b0; colisao = 1'b0;
    exp_disp = 1;

    // Cooldown length: a rise one frame early is dropped, right after is taken.
    fire = 1'b1; same("rise_in_recarga");
    fire = 1'b0; same("recarga_idle");
    for (int i = 0; i < 14; i++) begin
      frame_tick = 1'b1; same("cd_tick");
      frame_tick = 1'b0; same("cd_gap");
    end
    fire = 1'b1; same("rise_cd1_dropped");
    fire = 1'b0; same("cd1_gap");
    posX_player = 10'd100; posY_player = 10'd6;
    frame_tick = 1'b1; same("cd_last_tick");
    frame_tick = 1'b0; same("cd_exit");
    fire = 1'b1; exp_disp++;
    cyc("launch_y6", 10'd111, 10'd0, 1'b1, exp_disp);

    // Top exit from posY=0, then hold fire through the whole cooldown.
    frame_tick = 1'b1;
    cyc("top_exit", 10'd1023, 10'd1023, 1'b0, exp_disp);
    frame_tick = 1'b0;
    posY_player = 10'd3;
    for (int i = 0; i < 15; i++) begin
      frame_tick = 1'b1; same("held_tick");
      frame_tick = 1'b0; same("held_gap");
    end
`ifdef MUNICAO_AUTOFIRE_EN
    exp_disp++;
    cyc("autofire_relaunch", 10'd111, 10'd0, 1'b1, exp_disp);
    same("autofire_hold");
`else
    same("held_no_relaunch");
    same("held_no_relaunch2");
    fire = 1'b0; same("release");
    fire = 1'b1; exp_disp++;
    cyc("launch_clamp", 10'd111, 10'd0, 1'b1, exp_disp);
`endif

    // Hit retires; colisao is ignored during cooldown.
    fire = 1'b0; colisao = 1'b1;
    cyc("hit", 10'd1023, 10'd1023, 1'b0, exp_disp);
    same("col_in_recarga");
    colisao = 1'b0;
    fast_cooldown("cd2");

    // Pixel path around a stationary bullet at (311,434).
    posX_player = 10'd300; posY_player = 10'd440;
    fire = 1'b1; exp_disp++;
    cyc("launch_pix", 10'd311, 10'd434, 1'b1, exp_disp);
    fire = 1'b0;
    h_counter = 10'd311; v_counter = 10'd434; same("pix_tl");
    h_counter = 10'd312; v_counter = 10'd439; same("pix_br");
    h_counter = 10'd313; v_counter = 10'd434; same("pix_right_out");
    h_counter = 10'd310; v_counter = 10'd434; same("pix_left_out");
    h_counter = 10'd311; v_counter = 10'd440; same("pix_below_out");
    h_counter = 10'd311; v_counter = 10'd433; same("pix_above_out");
    h_counter = 10'd0;   v_counter = 10'd0;   same("pix_clear");
    colisao = 1'b1;
    cyc("hit_pix", 10'd1023, 10'd1023, 1'b0, exp_disp);
    colisao = 1'b0;
    h_counter = 10'd1023; v_counter = 10'd1023; same("pix_inactive_sentinel");
    h_counter = 10'd0;    v_counter = 10'd0;

    // Launch counter through the 255 -> 0 wrap.
    while (exp_disp < 256) begin
      fast_cooldown("wrap_cd");
      fire = 1'b1; exp_disp++;
      cyc((exp_disp == 256) ? "wrap_launch_256" : "wrap_launch",
          10'd311, 10'd434, 1'b1, exp_disp);
      fire = 1'b0; colisao = 1'b1;
      cyc("wrap_hit", 10'd1023, 10'd1023, 1'b0, exp_disp);
      colisao = 1'b0;
    end

    // Asynchronous reset while a bullet is in flight and being painted.
    fast_cooldown("pre_reset_cd");
    fire = 1'b1; exp_disp++;
    cyc("launch_pre_reset", 10'd311, 10'd434, 1'b1, exp_disp);
    fire = 1'b0;
    h_counter = 10'd311; v_counter = 10'd434;
    same("pix_pre_reset");
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset.posX", 32'(posX_municao_player), 32'd1023);
    chk("async_reset.posY", 32'(posY_municao_player), 32'd1023);
    chk("async_reset.ativa", 32'(ativa), 32'd0);
    chk("async_reset.disparos", 32'(disparos), 32'd0);
    chk("async_reset.rgb", 32'({R, G, B}), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_held.rgb", 32'({R, G, B}), 32'd0);
    chk("reset_held.posY", 32'(posY_municao_player), 32'd1023);
    reset = 1'b1;
    set_prev_reset();
    h_counter = 10'd0; v_counter = 10'd0;
    same("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
